mem_wb_pipe_stage: RTL and testbench
====================================

Name: mem_wb_pipe_stage

Overview:
- Parametrised MEM->WB pipeline stage; successor to the plain MEM/WB register.
- Adds a valid/ready handshake, a 2-entry skid buffer for back-pressure, and synchronous flush.
- Selects writeback data (load value vs ALU result) before registering, and qualifies the register-file write enable.
- Sits between the memory-access stage and the register-file write port.

Parameters:
- DATA_W, 32, width of result, load value and writeback data
- REG_ADDR_W, 5, width of destination register index
- SUPPRESS_R0, 1, when 1 a write to register index 0 never asserts rf_write_enable or forwarding hits

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; equals NOT skid_valid
- destination_input  in  REG_ADDR_W  destination register
- result_input  in  DATA_W  ALU result
- loadvalue_input  in  DATA_W  memory load data
- MEMORY_READ_input  in  1  entry is a load
- WRITEBACK_input  in  1  entry writes the register file
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts the main entry
- destination_output  out  REG_ADDR_W  registered destination
- writeback_data_output  out  DATA_W  registered selected data
- MEMORY_READ_output  out  1  registered load flag
- WRITEBACK_output  out  1  registered writeback flag, ANDed with out_valid
- rf_write_enable  out  1  out_valid AND out_ready AND WRITEBACK, with R0 suppression
- fwd_rs1, fwd_rs2  in  REG_ADDR_W  forwarding lookup indices
- fwd_hit_rs1, fwd_hit_rs2  out  1  forwarding match
- fwd_data  out  DATA_W  forwarding value

Behaviour:
- Reset is asynchronous and active-low on reset_n. While reset_n is low:
  - main_valid and skid_valid are 0.
  - All data registers are 0.
  - All outputs are 0 except in_ready, which is 1.
  - Handshakes presented during reset are ignored.
- Selection at input: sel = MEMORY_READ_input ? loadvalue_input : result_input. Each entry stores {dest, sel, mem_read, wb}.
- Accept: in_valid AND in_ready at a rising edge. Latency from accept to out_valid is 1 cycle when main is empty or draining.
- Pop: out_valid AND out_ready.
- State machine on {main_valid, skid_valid}; EMPTY={0,0}, ONE={1,0}, FULL={1,1}:
  - EMPTY + accept -> ONE (main <= in).
  - ONE + accept + pop -> ONE (main <= in).
  - ONE + accept, no pop -> FULL (skid <= in).
  - ONE + pop, no accept -> EMPTY.
  - FULL + pop -> ONE (main <= skid). No accept is possible because in_ready = 0.
  - FULL, no pop -> hold.
- in_ready derives only from the skid_valid register. It has no combinational path from out_ready.
- Flush has priority over everything. The next state is EMPTY, and an accept or pop in the same cycle is discarded. Data registers may hold stale values; outputs qualified by valid read as 0. rf_write_enable is forced to 0 in the flush cycle.
- Order is preserved. No entry is duplicated or dropped except by flush or reset.
- Reset asserted mid-operation: immediate return to EMPTY.
- SUPPRESS_R0=1 with destination 0:
  - rf_write_enable = 0 and forwarding hits = 0.
  - The entry still flows through the stage normally.

Optional Feature:
- MEM_WB_FWD_EN defined:
  - fwd_hit_rsX = main_valid AND main.wb AND (main.dest == fwd_rsX) AND NOT(SUPPRESS_R0 AND dest == 0).
  - fwd_data = main.sel. The path is combinational from registers and the fwd_rs inputs.
- Not defined: fwd_hit_rs1, fwd_hit_rs2 and fwd_data are tied to 0. The compare logic is not synthesised. Ports stay present.

Decomposition:
- Package mem_wb_pkg:
  - DATA_W and REG_ADDR_W defaults.
  - mem_wb_entry_t struct {dest, data, mem_read, wb}.
  - State encoding constants EMPTY, ONE, FULL.
- One natural sub-module: mem_wb_skid_buf. It is a generic 2-entry valid/ready skid buffer over mem_wb_entry_t, with a flush input. The top level holds the input selection, write qualification and forwarding.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with in_valid=1.
  - Required: out_valid=0, in_ready=1, rf_write_enable=0 throughout.
  - Required: after release, no phantom entry appears.
- Streaming: out_ready=1; send {dest=5, result=0x11, MEMORY_READ=0, WB=1}, then {dest=6, loadvalue=0xAB, MEMORY_READ=1, WB=1} on back-to-back cycles.
  - Required: writeback_data_output = 0x11, then 0xAB, one cycle after each accept.
  - Required: rf_write_enable high in both cycles.
- Back-pressure: out_ready=0; accept A (dest=3), then B (dest=4).
  - Required: in_ready=0 after B.
  - Required: raising out_ready pops A, then B, in order; in_ready returns to 1 one cycle after A pops.
- Flush in FULL: assert flush with in_valid=1 and out_ready=1.
  - Required: next cycle out_valid=0, in_ready=1, rf_write_enable=0.
  - Required: the flushed-cycle input never appears at the output.
- R0 suppression: SUPPRESS_R0=1, dest=0, WB=1, result=0xFFFF.
  - Required: out_valid=1, rf_write_enable=0, fwd_hit_rs1=0 with fwd_rs1=0.
- Forwarding (MEM_WB_FWD_EN defined): main holds {dest=7, sel=0x1234, WB=1}; fwd_rs1=7, fwd_rs2=8.
  - Required: fwd_hit_rs1=1, fwd_hit_rs2=0, fwd_data=0x1234.
  - Required (macro undefined): all forwarding outputs are 0.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM->WB pipeline stage: default widths, entry layout, occupancy states.
package mem_wb_pkg;

    localparam int unsigned MEM_WB_DATA_W     = 32;
    localparam int unsigned MEM_WB_REG_ADDR_W = 5;

    typedef struct packed {
        logic [MEM_WB_REG_ADDR_W-1:0] dest;
        logic [MEM_WB_DATA_W-1:0]     data;
        logic                         mem_read;
        logic                         wb;
    } mem_wb_entry_t;

    // Encoded as {main_valid, skid_valid}
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } mem_wb_state_e;

endpackage

// File: rtl/mem_wb_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush; payload is an opaque
// vector, sized by default to one mem_wb_entry_t.
module mem_wb_skid_buf
    import mem_wb_pkg::*;
#(
    parameter int unsigned W = $bits(mem_wb_entry_t)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    mem_wb_state_e state_q, state_d;
    logic [W-1:0]  main_q, main_d;
    logic [W-1:0]  skid_q, skid_d;
    logic          accept;
    logic          pop;

    // Both handshake outputs come straight from the state register.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign out_data  = main_q;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB stage: writeback data selection, skid-buffered handshake, write qualification.
// Optional forwarding compare enabled by defining MEM_WB_FWD_EN.
module mem_wb_pipe_stage
    import mem_wb_pkg::*;
#(
    parameter int unsigned DATA_W      = MEM_WB_DATA_W,
    parameter int unsigned REG_ADDR_W  = MEM_WB_REG_ADDR_W,
    parameter int unsigned SUPPRESS_R0 = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] destination_input,
    input  logic [DATA_W-1:0]     result_input,
    input  logic [DATA_W-1:0]     loadvalue_input,
    input  logic                  MEMORY_READ_input,
    input  logic                  WRITEBACK_input,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] destination_output,
    output logic [DATA_W-1:0]     writeback_data_output,
    output logic                  MEMORY_READ_output,
    output logic                  WRITEBACK_output,
    output logic                  rf_write_enable,
    input  logic [REG_ADDR_W-1:0] fwd_rs1,
    input  logic [REG_ADDR_W-1:0] fwd_rs2,
    output logic                  fwd_hit_rs1,
    output logic                  fwd_hit_rs2,
    output logic [DATA_W-1:0]     fwd_data
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
        logic                  mem_read;
        logic                  wb;
    } entry_t;

    entry_t                    in_entry;
    entry_t                    main_entry;
    logic [$bits(entry_t)-1:0] main_bits;
    logic                      dest_is_r0;

    always_comb begin
        in_entry.dest     = destination_input;
        in_entry.data     = MEMORY_READ_input ? loadvalue_input : result_input;
        in_entry.mem_read = MEMORY_READ_input;
        in_entry.wb       = WRITEBACK_input;
    end

    mem_wb_skid_buf #(
        .W($bits(entry_t))
    ) u_skid (
        .clk      (clock),
        .rst_n    (reset_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_entry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (main_bits)
    );

    assign main_entry = main_bits;
    assign dest_is_r0 = (SUPPRESS_R0 != 0) && (main_entry.dest == '0);

    assign destination_output    = main_entry.dest;
    assign writeback_data_output = main_entry.data;
    assign MEMORY_READ_output    = main_entry.mem_read;
    assign WRITEBACK_output      = main_entry.wb && out_valid;
    assign rf_write_enable       = out_valid && out_ready && main_entry.wb && !flush && !dest_is_r0;

`ifdef MEM_WB_FWD_EN
    assign fwd_hit_rs1 = out_valid && main_entry.wb && (main_entry.dest == fwd_rs1) && !dest_is_r0;
    assign fwd_hit_rs2 = out_valid && main_entry.wb && (main_entry.dest == fwd_rs2) && !dest_is_r0;
    assign fwd_data    = main_entry.data;
`else
    logic unused_fwd;
    assign unused_fwd  = ^{fwd_rs1, fwd_rs2};
    assign fwd_hit_rs1 = 1'b0;
    assign fwd_hit_rs2 = 1'b0;
    assign fwd_data    = '0;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Table-driven bench for mem_wb_pipe_stage with an in-order scoreboard of accepted entries.
module tb_mem_wb_pipe_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  destination_input;
    logic [31:0] result_input;
    logic [31:0] loadvalue_input;
    logic        MEMORY_READ_input;
    logic        WRITEBACK_input;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  destination_output;
    logic [31:0] writeback_data_output;
    logic        MEMORY_READ_output;
    logic        WRITEBACK_output;
    logic        rf_write_enable;
    logic [4:0]  fwd_rs1;
    logic [4:0]  fwd_rs2;
    logic        fwd_hit_rs1;
    logic        fwd_hit_rs2;
    logic [31:0] fwd_data;

    always #5 clock = ~clock;

    mem_wb_pipe_stage #(
        .DATA_W     (32),
        .REG_ADDR_W (5),
        .SUPPRESS_R0(1)
    ) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .flush                (flush),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .destination_input    (destination_input),
        .result_input         (result_input),
        .loadvalue_input      (loadvalue_input),
        .MEMORY_READ_input    (MEMORY_READ_input),
        .WRITEBACK_input      (WRITEBACK_input),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .destination_output   (destination_output),
        .writeback_data_output(writeback_data_output),
        .MEMORY_READ_output   (MEMORY_READ_output),
        .WRITEBACK_output     (WRITEBACK_output),
        .rf_write_enable      (rf_write_enable),
        .fwd_rs1              (fwd_rs1),
        .fwd_rs2              (fwd_rs2),
        .fwd_hit_rs1          (fwd_hit_rs1),
        .fwd_hit_rs2          (fwd_hit_rs2),
        .fwd_data             (fwd_data)
    );

    typedef struct {
        logic        iv;
        logic [4:0]  dest;
        logic [31:0] res;
        logic [31:0] ld;
        logic        mr;
        logic        wb;
        logic        ordy;
        logic        fl;
        logic [4:0]  frs1;
        logic [4:0]  frs2;
        logic        irdy;
        logic        ovld;
        logic        rfwe;
        logic        hit1;
        logic        hit2;
        logic        fchk;
        logic [31:0] fdata;
    } vec_t;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
        logic        mr;
        logic        wb;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t tbl[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic iv, input logic [4:0] dest, input logic [31:0] res,
                               input logic [31:0] ld, input logic mr, input logic wb,
                               input logic ordy, input logic fl, input logic irdy,
                               input logic ovld, input logic rfwe);
        vec_t r;
        r.iv = iv; r.dest = dest; r.res = res; r.ld = ld; r.mr = mr; r.wb = wb;
        r.ordy = ordy; r.fl = fl; r.irdy = irdy; r.ovld = ovld; r.rfwe = rfwe;
        r.frs1 = 5'd31; r.frs2 = 5'd31; r.hit1 = 1'b0; r.hit2 = 1'b0;
        r.fchk = 1'b0; r.fdata = '0;
        return r;
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0; destination_input = '0; result_input = '0; loadvalue_input = '0;
        MEMORY_READ_input = 1'b0; WRITEBACK_input = 1'b0; flush = 1'b0;
        out_ready = 1'b1; fwd_rs1 = 5'd31; fwd_rs2 = 5'd31;
    endtask

    initial begin
        exp_t e;
        logic eh1, eh2;

        //             iv dest   res       ld      mr wb ordy fl  irdy ovld rfwe
        tbl[0]  = v(1, 5,  32'h11,   32'h0,  0, 1, 1, 0,  1, 0, 0);
        tbl[1]  = v(1, 6,  32'h66,   32'hAB, 1, 1, 1, 0,  1, 1, 1);
        tbl[2]  = v(0, 0,  32'h0,    32'h0,  0, 0, 1, 0,  1, 1, 1);
        tbl[3]  = v(1, 3,  32'h33,   32'h0,  0, 1, 0, 0,  1, 0, 0);
        tbl[4]  = v(1, 4,  32'h44,   32'h0,  0, 1, 0, 0,  1, 1, 0);
        tbl[5]  = v(1, 9,  32'h99,   32'h0,  0, 1, 0, 0,  0, 1, 0);
        tbl[6]  = v(0, 0,  32'h0,    32'h0,  0, 0, 1, 0,  0, 1, 1);
        tbl[7]  = v(0, 0,  32'h0,    32'h0,  0, 0, 1, 0,  1, 1, 1);
        tbl[8]  = v(1, 10, 32'hA0,   32'h0,  0, 1, 0, 0,  1, 0, 0);
        tbl[9]  = v(1, 11, 32'hB0,   32'h0,  0, 1, 0, 0,  1, 1, 0);
        tbl[10] = v(1, 12, 32'hC0,   32'h0,  0, 1, 1, 1,  0, 1, 0);
        tbl[11] = v(0, 0,  32'h0,    32'h0,  0, 0, 1, 0,  1, 0, 0);
        tbl[12] = v(1, 13, 32'hD0,   32'h0,  0, 1, 1, 0,  1, 0, 0);
        tbl[13] = v(1, 14, 32'hE0,   32'h0,  0, 1, 1, 1,  1, 1, 0);
        tbl[14] = v(0, 0,  32'h0,    32'h0,  0, 0, 1, 0,  1, 0, 0);
        tbl[15] = v(1, 0,  32'hFFFF, 32'h0,  0, 1, 0, 0,  1, 0, 0);
        tbl[16] = v(0, 0,  32'h0,    32'h0,  0, 0, 1, 0,  1, 1, 0);
        tbl[17] = v(1, 7,  32'h77,   32'h55, 1, 0, 1, 0,  1, 0, 0);
        tbl[18] = v(0, 0,  32'h0,    32'h0,  0, 0, 1, 0,  1, 1, 0);
        tbl[19] = v(1, 7,  32'h1234, 32'h0,  0, 1, 0, 0,  1, 0, 0);
        tbl[20] = v(0, 0,  32'h0,    32'h0,  0, 0, 0, 0,  1, 1, 0);
        tbl[21] = v(0, 0,  32'h0,    32'h0,  0, 0, 1, 0,  1, 1, 1);
        tbl[16].frs1 = 5'd0;
        tbl[18].frs1 = 5'd7;
        tbl[20].frs1 = 5'd7; tbl[20].frs2 = 5'd8; tbl[20].hit1 = 1'b1;
        tbl[20].fchk = 1'b1; tbl[20].fdata = 32'h1234;

        // Reset held for 3 cycles with handshakes offered
        reset_n = 1'b0;
        idle_inputs();
        in_valid = 1'b1; destination_input = 5'd1; result_input = 32'hDEAD; WRITEBACK_input = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            chk("rst_out_valid", {31'b0, out_valid}, 0);
            chk("rst_in_ready", {31'b0, in_ready}, 1);
            chk("rst_rf_we", {31'b0, rf_write_enable}, 0);
            chk("rst_wb_out", {31'b0, WRITEBACK_output}, 0);
            chk("rst_data", writeback_data_output, 0);
        end
        @(negedge clock);
        idle_inputs();
        reset_n = 1'b1;

        for (int r = 0; r < 22; r++) begin
            @(negedge clock);
            in_valid = tbl[r].iv; destination_input = tbl[r].dest;
            result_input = tbl[r].res; loadvalue_input = tbl[r].ld;
            MEMORY_READ_input = tbl[r].mr; WRITEBACK_input = tbl[r].wb;
            out_ready = tbl[r].ordy; flush = tbl[r].fl;
            fwd_rs1 = tbl[r].frs1; fwd_rs2 = tbl[r].frs2;
            #1;
            chk($sformatf("r%0d_in_ready", r), {31'b0, in_ready}, {31'b0, tbl[r].irdy});
            chk($sformatf("r%0d_out_valid", r), {31'b0, out_valid}, {31'b0, tbl[r].ovld});
            chk($sformatf("r%0d_rf_we", r), {31'b0, rf_write_enable}, {31'b0, tbl[r].rfwe});
`ifdef MEM_WB_FWD_EN
            eh1 = tbl[r].hit1; eh2 = tbl[r].hit2;
            if (tbl[r].fchk) chk($sformatf("r%0d_fwd_data", r), fwd_data, tbl[r].fdata);
`else
            eh1 = 1'b0; eh2 = 1'b0;
            chk($sformatf("r%0d_fwd_data", r), fwd_data, 0);
`endif
            chk($sformatf("r%0d_hit1", r), {31'b0, fwd_hit_rs1}, {31'b0, eh1});
            chk($sformatf("r%0d_hit2", r), {31'b0, fwd_hit_rs2}, {31'b0, eh2});
            if (tbl[r].ovld) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r%0d_sb_underflow: output valid expected but no entry queued", r);
                end else begin
                    e = sb[0];
                    chk($sformatf("r%0d_dest", r), {27'b0, destination_output}, {27'b0, e.dest});
                    chk($sformatf("r%0d_data", r), writeback_data_output, e.data);
                    chk($sformatf("r%0d_mem_read", r), {31'b0, MEMORY_READ_output}, {31'b0, e.mr});
                    chk($sformatf("r%0d_wb_out", r), {31'b0, WRITEBACK_output}, {31'b0, e.wb});
                    if (tbl[r].ordy && !tbl[r].fl) void'(sb.pop_front());
                end
            end else begin
                chk($sformatf("r%0d_wb_out_idle", r), {31'b0, WRITEBACK_output}, 0);
            end
            if (tbl[r].iv && tbl[r].irdy && !tbl[r].fl) begin
                e.dest = tbl[r].dest;
                e.data = tbl[r].mr ? tbl[r].ld : tbl[r].res;
                e.mr   = tbl[r].mr;
                e.wb   = tbl[r].wb;
                sb.push_back(e);
            end
            if (tbl[r].fl) sb.delete();
        end
        chk("sb_drained", sb.size(), 0);

        // Asynchronous reset in the middle of holding an entry
        @(negedge clock);
        idle_inputs();
        in_valid = 1'b1; destination_input = 5'd20; result_input = 32'h20;
        WRITEBACK_input = 1'b1; out_ready = 1'b0;
        @(negedge clock);
        idle_inputs();
        out_ready = 1'b0;
        #1;
        chk("mid_pre_valid", {31'b0, out_valid}, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 1);
        chk("mid_rst_dest", {27'b0, destination_output}, 0);
        chk("mid_rst_data", writeback_data_output, 0);
        @(negedge clock);
        reset_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_valid", {31'b0, out_valid}, 0);
        chk("post_rst_rf_we", {31'b0, rf_write_enable}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
